// File: rtl/gw2a_rpll_ctrl_if.sv
// Divider-set request channel into the GW2A rPLL lock supervisor.
// A request is taken on the rising edge where cfg_valid_i and cfg_ready_o are both high.
interface gw2a_rpll_ctrl_if;
  logic       cfg_valid_i;
  logic       cfg_ready_o;
  logic [5:0] cfg_idiv_i;
  logic [5:0] cfg_fbdiv_i;
  logic [5:0] cfg_odiv_i;

  modport master (
    output cfg_valid_i,
    output cfg_idiv_i,
    output cfg_fbdiv_i,
    output cfg_odiv_i,
    input  cfg_ready_o
  );

  modport slave (
    input  cfg_valid_i,
    input  cfg_idiv_i,
    input  cfg_fbdiv_i,
    input  cfg_odiv_i,
    output cfg_ready_o
  );
endinterface

// File: rtl/gw2a_rpll_ctrl.sv
// GW2A rPLL lock supervisor: sequences PLL reset, qualifies LOCK with debounce and timeout,
// retries failed attempts, re-locks on lock loss and applies new divider codes at run time.
module gw2a_rpll_ctrl #(
  parameter int IDIV_DEF     = 8,
  parameter int FBDIV_DEF    = 39,
  parameter int ODIV_DEF     = 8,
  parameter int RST_CYCLES   = 16,
  parameter int LOCK_STABLE  = 256,
  parameter int LOCK_TIMEOUT = 65536,
  parameter int MAX_RETRY    = 3,
  parameter int CNTW         = 8
) (
  input  logic                clock,
  input  logic                resetn,
  gw2a_rpll_ctrl_if.slave     cfg,
  input  logic                pll_lock_i,
  output logic                pll_reset_o,
  output logic [5:0]          pll_idsel_o,
  output logic [5:0]          pll_fbdsel_o,
  output logic [5:0]          pll_odsel_o,
  output logic                locked_o,
  output logic                fail_o,
  output logic [CNTW-1:0]     relock_count_o
);

  localparam int HW = $clog2(RST_CYCLES);
  localparam int SW = $clog2(LOCK_STABLE + 1);
  localparam int TW = $clog2(LOCK_TIMEOUT + 1);
  localparam int RW = $clog2(MAX_RETRY + 1);

  localparam logic [HW-1:0] HOLD_LAST   = HW'(RST_CYCLES - 1);
  localparam logic [SW-1:0] STABLE_LAST = SW'(LOCK_STABLE - 1);
  localparam logic [TW-1:0] TMO_LAST    = TW'(LOCK_TIMEOUT - 1);
  localparam logic [RW-1:0] RETRY_MAX   = RW'(MAX_RETRY);

  typedef enum logic [1:0] {
    ST_HOLD   = 2'd0,
    ST_WAIT   = 2'd1,
    ST_LOCKED = 2'd2,
    ST_FAIL   = 2'd3
  } state_t;

  state_t          state_reg, state_next;
  logic [HW-1:0]   hold_reg, hold_next;
  logic [SW-1:0]   stable_reg, stable_next;
  logic [TW-1:0]   tmo_reg, tmo_next;
  logic [RW-1:0]   retry_reg, retry_next;
  logic [RW-1:0]   retry_inc;
  logic            pll_reset_reg, pll_reset_next;
  logic            locked_reg, locked_next;
  logic            fail_reg, fail_next;
  logic            ready_reg, ready_next;
  logic [CNTW-1:0] relock_reg, relock_next;
  logic [5:0]      idiv_reg, idiv_next;
  logic [5:0]      fbdiv_reg, fbdiv_next;
  logic [5:0]      odiv_reg, odiv_next;
  logic            lk_meta_reg;
  logic            lk_s;
  logic            accept;

  // LOCK arrives asynchronously; only the second flop feeds the control logic.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      lk_meta_reg <= 1'b0;
      lk_s        <= 1'b0;
    end else begin
      lk_meta_reg <= pll_lock_i;
      lk_s        <= lk_meta_reg;
    end
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_reg     <= ST_HOLD;
      hold_reg      <= '0;
      stable_reg    <= '0;
      tmo_reg       <= '0;
      retry_reg     <= '0;
      pll_reset_reg <= 1'b1;
      locked_reg    <= 1'b0;
      fail_reg      <= 1'b0;
      ready_reg     <= 1'b0;
      relock_reg    <= '0;
      idiv_reg      <= 6'(IDIV_DEF);
      fbdiv_reg     <= 6'(FBDIV_DEF);
      odiv_reg      <= 6'(ODIV_DEF);
    end else begin
      state_reg     <= state_next;
      hold_reg      <= hold_next;
      stable_reg    <= stable_next;
      tmo_reg       <= tmo_next;
      retry_reg     <= retry_next;
      pll_reset_reg <= pll_reset_next;
      locked_reg    <= locked_next;
      fail_reg      <= fail_next;
      ready_reg     <= ready_next;
      relock_reg    <= relock_next;
      idiv_reg      <= idiv_next;
      fbdiv_reg     <= fbdiv_next;
      odiv_reg      <= odiv_next;
    end
  end

  // ready_reg is high exactly in LOCKED and FAIL, so it also gates where accepts can happen.
  assign accept    = cfg.cfg_valid_i && ready_reg;
  assign retry_inc = retry_reg + 1'b1;

  always_comb begin
    state_next     = state_reg;
    hold_next      = hold_reg;
    stable_next    = stable_reg;
    tmo_next       = tmo_reg;
    retry_next     = retry_reg;
    pll_reset_next = pll_reset_reg;
    locked_next    = locked_reg;
    fail_next      = fail_reg;
    ready_next     = ready_reg;
    relock_next    = relock_reg;
    idiv_next      = idiv_reg;
    fbdiv_next     = fbdiv_reg;
    odiv_next      = odiv_reg;

    case (state_reg)
      ST_HOLD: begin
        if (hold_reg == HOLD_LAST) begin
          state_next     = ST_WAIT;
          pll_reset_next = 1'b0;
          stable_next    = '0;
          tmo_next       = '0;
        end else begin
          hold_next = hold_reg + 1'b1;
        end
      end

      ST_WAIT: begin
        tmo_next    = tmo_reg + 1'b1;
        stable_next = lk_s ? stable_reg + 1'b1 : '0;
        // A lock completing on the timeout cycle still counts as a lock.
        if (lk_s && (stable_reg == STABLE_LAST)) begin
          state_next  = ST_LOCKED;
          locked_next = 1'b1;
          ready_next  = 1'b1;
        end else if (tmo_reg == TMO_LAST) begin
          retry_next     = retry_inc;
          pll_reset_next = 1'b1;
          hold_next      = '0;
          if (retry_inc < RETRY_MAX) begin
            state_next = ST_HOLD;
          end else begin
            state_next = ST_FAIL;
            fail_next  = 1'b1;
            ready_next = 1'b1;
          end
        end
      end

      ST_LOCKED, ST_FAIL: begin
        if (accept || (state_reg == ST_LOCKED && !lk_s)) begin
          state_next     = ST_HOLD;
          hold_next      = '0;
          retry_next     = '0;
          pll_reset_next = 1'b1;
          locked_next    = 1'b0;
          ready_next     = 1'b0;
          fail_next      = 1'b0;
          if (accept) begin
            idiv_next  = cfg.cfg_idiv_i;
            fbdiv_next = cfg.cfg_fbdiv_i;
            odiv_next  = cfg.cfg_odiv_i;
          end else if (relock_reg != {CNTW{1'b1}}) begin
            relock_next = relock_reg + 1'b1;
          end
        end
      end

      default: begin
        state_next = ST_HOLD;
      end
    endcase
  end

  assign cfg.cfg_ready_o  = ready_reg;
  assign pll_reset_o      = pll_reset_reg;
  assign pll_idsel_o      = idiv_reg;
  assign pll_fbdsel_o     = fbdiv_reg;
  assign pll_odsel_o      = odiv_reg;
  assign locked_o         = locked_reg;
  assign fail_o           = fail_reg;
  assign relock_count_o   = relock_reg;

endmodule

// File: tb/tb_gw2a_rpll_ctrl.sv
// Directed bench for gw2a_rpll_ctrl: power-up, lock loss, glitchy lock, reconfig,
// timeout/retry into FAIL, recovery from FAIL and mid-operation reset.
module tb_gw2a_rpll_ctrl;
  logic       clock;
  logic       resetn;
  logic       pll_lock_i;
  logic       pll_reset_o;
  logic [5:0] pll_idsel_o;
  logic [5:0] pll_fbdsel_o;
  logic [5:0] pll_odsel_o;
  logic       locked_o;
  logic       fail_o;
  logic [3:0] relock_count_o;

  int n_cmp = 0;
  int n_err = 0;

  gw2a_rpll_ctrl_if cfg_if ();

  gw2a_rpll_ctrl #(
    .IDIV_DEF(8), .FBDIV_DEF(39), .ODIV_DEF(8),
    .RST_CYCLES(4), .LOCK_STABLE(8), .LOCK_TIMEOUT(64), .MAX_RETRY(2), .CNTW(4)
  ) dut (
    .clock          (clock),
    .resetn         (resetn),
    .cfg            (cfg_if.slave),
    .pll_lock_i     (pll_lock_i),
    .pll_reset_o    (pll_reset_o),
    .pll_idsel_o    (pll_idsel_o),
    .pll_fbdsel_o   (pll_fbdsel_o),
    .pll_odsel_o    (pll_odsel_o),
    .locked_o       (locked_o),
    .fail_o         (fail_o),
    .relock_count_o (relock_count_o)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end else begin
      $display("ok   %s = %0d", tag, got);
    end
  endtask

  task automatic tick();
    @(negedge clock);
  endtask

  // Ticks until pll_reset_o leaves level lvl; n is the number of edges taken.
  task automatic measure(input logic lvl, output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (pll_reset_o == lvl && n < 300);
  endtask

  task automatic wait_lock(output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!locked_o && n < 300);
  endtask

  task automatic set_cfg(input logic v, input int a, input int b, input int c);
    cfg_if.cfg_valid_i = v;
    cfg_if.cfg_idiv_i  = 6'(a);
    cfg_if.cfg_fbdiv_i = 6'(b);
    cfg_if.cfg_odiv_i  = 6'(c);
  endtask

  function automatic int divs();
    return int'({pll_idsel_o, pll_fbdsel_o, pll_odsel_o});
  endfunction

  function automatic int pack(input int a, input int b, input int c);
    return (a << 12) | (b << 6) | c;
  endfunction

  initial begin
    int n, m, bad, hi_seen, exp_cnt;
    resetn     = 1'b0;
    pll_lock_i = 1'b0;
    set_cfg(1'b0, 0, 0, 0);
    repeat (3) tick();

    check("rst_pll_reset", pll_reset_o, 1);
    check("rst_locked", locked_o, 0);
    check("rst_fail", fail_o, 0);
    check("rst_ready", cfg_if.cfg_ready_o, 0);
    check("rst_relock", relock_count_o, 0);
    check("rst_divs", divs(), pack(8, 39, 8));

    // Power-up: lock raised 10 cycles after the reset falls.
    resetn = 1'b1;
    measure(1'b1, n);
    check("pwr_hold_len", n, 4);
    repeat (10) tick();
    pll_lock_i = 1'b1;
    wait_lock(m);
    check("pwr_lock_lat", 10 + m, 20);
    check("pwr_ready", cfg_if.cfg_ready_o, 1);
    check("pwr_divs", divs(), pack(8, 39, 8));

    // Accept and lock loss on the same edge: accept wins, no relock count.
    pll_lock_i = 1'b0;
    repeat (2) tick();
    set_cfg(1'b1, 3, 30, 5);
    tick();
    check("same_divs", divs(), pack(3, 30, 5));
    check("same_relock", relock_count_o, 0);
    check("same_locked", locked_o, 0);
    check("same_reset", pll_reset_o, 1);
    set_cfg(1'b0, 0, 0, 0);
    pll_lock_i = 1'b1;
    measure(1'b1, n);
    check("same_hold_len", n, 4);
    wait_lock(m);
    check("same_relock_lat", m, 8);

    // Glitchy lock after a loss: runs of 5 highs never qualify.
    pll_lock_i = 1'b0;
    repeat (3) tick();
    hi_seen = 0;
    for (int r = 0; r < 4; r++) begin
      pll_lock_i = 1'b1;
      for (int k = 0; k < 5; k++) begin
        tick();
        if (locked_o) hi_seen++;
      end
      pll_lock_i = 1'b0;
      tick();
      if (locked_o) hi_seen++;
    end
    check("glitch_no_lock", hi_seen, 0);
    pll_lock_i = 1'b1;
    wait_lock(m);
    check("glitch_lock_lat", m, 10);
    check("glitch_relock", relock_count_o, 1);

    // Fifteen more plain losses; count saturates at 15.
    for (int i = 2; i <= 16; i++) begin
      pll_lock_i = 1'b0;
      repeat (3) tick();
      check("loss_locked", locked_o, 0);
      pll_lock_i = 1'b1;
      measure(1'b1, n);
      check("loss_hold_len", n, 4);
      wait_lock(m);
      check("loss_relock_lat", m, 8);
      exp_cnt = (i < 15) ? i : 15;
      check("loss_count", relock_count_o, exp_cnt);
    end

    // Reconfig from LOCKED with valid raised while the controller is busy.
    pll_lock_i = 1'b0;
    repeat (3) tick();
    pll_lock_i = 1'b1;
    set_cfg(1'b1, 2, 20, 4);
    n = 0;
    bad = 0;
    while (!cfg_if.cfg_ready_o && n < 300) begin
      if (divs() != pack(3, 30, 5)) bad++;
      tick();
      n++;
    end
    check("cfg_busy_len", n, 12);
    check("cfg_busy_divs", bad, 0);
    check("cfg_pre_divs", divs(), pack(3, 30, 5));
    tick();
    check("cfg_acc_divs", divs(), pack(2, 20, 4));
    check("cfg_acc_ready", cfg_if.cfg_ready_o, 0);
    check("cfg_acc_locked", locked_o, 0);
    check("cfg_acc_reset", pll_reset_o, 1);
    set_cfg(1'b0, 0, 0, 0);
    measure(1'b1, n);
    check("cfg_hold_len", n, 4);
    check("cfg_hold_divs", divs(), pack(2, 20, 4));
    wait_lock(m);
    check("cfg_relock_lat", m, 8);
    check("cfg_relock_ready", cfg_if.cfg_ready_o, 1);
    check("cfg_relock_cnt", relock_count_o, 15);

    // Timeout/retry: lock stays low through two attempts.
    pll_lock_i = 1'b0;
    repeat (3) tick();
    measure(1'b1, n);
    check("tmo_hold1", n, 4);
    measure(1'b0, n);
    check("tmo_wait1", n, 64);
    check("tmo_fail_mid", fail_o, 0);
    measure(1'b1, n);
    check("tmo_hold2", n, 4);
    measure(1'b0, n);
    check("tmo_wait2", n, 64);
    repeat (5) tick();
    check("tmo_fail", fail_o, 1);
    check("tmo_reset", pll_reset_o, 1);
    check("tmo_ready", cfg_if.cfg_ready_o, 1);
    check("tmo_locked", locked_o, 0);

    // Recovery from FAIL through a new divider set.
    set_cfg(1'b1, 6, 33, 3);
    tick();
    check("fcfg_fail", fail_o, 0);
    check("fcfg_ready", cfg_if.cfg_ready_o, 0);
    check("fcfg_divs", divs(), pack(6, 33, 3));
    set_cfg(1'b0, 0, 0, 0);
    pll_lock_i = 1'b1;
    measure(1'b1, n);
    check("fcfg_hold_len", n, 4);
    wait_lock(m);
    check("fcfg_relock_lat", m, 8);
    check("fcfg_fail_after", fail_o, 0);

    // Mid-operation reset while in WAIT with a request held.
    pll_lock_i = 1'b0;
    repeat (3) tick();
    measure(1'b1, n);
    repeat (5) tick();
    resetn = 1'b0;
    set_cfg(1'b1, 9, 9, 9);
    tick();
    check("mrst_reset", pll_reset_o, 1);
    check("mrst_locked", locked_o, 0);
    check("mrst_fail", fail_o, 0);
    check("mrst_ready", cfg_if.cfg_ready_o, 0);
    check("mrst_relock", relock_count_o, 0);
    check("mrst_divs", divs(), pack(8, 39, 8));
    repeat (2) tick();
    resetn = 1'b1;
    set_cfg(1'b0, 0, 0, 0);
    pll_lock_i = 1'b1;
    measure(1'b1, n);
    check("mrst_hold_len", n, 4);
    wait_lock(m);
    check("mrst_lock_lat", m, 8);
    check("mrst_divs_after", divs(), pack(8, 39, 8));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
